bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter that owns the 8-bit source-select path of the MAP core. It decides which of the four bus sources drives the data multiplexer, and drives that multiplexer's 2-bit select directly. Each source holds a request for the length of a burst. The arbiter grants one source at a time, counts beats, and forces release after a bounded burst so that no source starves. A one-cycle dead slot separates consecutive owners.

## Interface
- MAX_BURST, default 8: maximum beats per grant before forced release; legal range 1..255.

- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ  in  4  request per source; bit0=X1, bit1=X2, bit2=X3, bit3=X4; held high for the whole burst.
- LAST  in  1  owner's final beat; sampled only on a VALID cycle.
- SEL  out  2  mux select; 00=X1, 01=X2, 10=X3, 11=X4; registered.
- GNT  out  4  one-hot grant, or 0000 when no source owns the bus; registered.
- VALID  out  1  mux output is a live beat this cycle.
- BUSY  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, OWN, RELEASE.
- Internal registers:
  - owner[1:0], equal to SEL.
  - last_owner[1:0], reset 11.
  - beat_cnt[7:0], reset 0.
- Reset values: state=IDLE, GNT=0000, SEL=00, VALID=0, BUSY=0, last_owner=11, beat_cnt=0.
- Arbitration is evaluated in IDLE and in RELEASE.
  - Priority order is last_owner+1, last_owner+2, last_owner+3, last_owner (all mod 4).
  - The first requesting index in that order wins.
  - Because last_owner resets to 11, X1 wins first after reset.
- Grant (on the edge leaving IDLE or RELEASE with REQ≠0000):
  - state=OWN.
  - GNT = one-hot of the winner; SEL = owner = winner; last_owner = winner.
  - beat_cnt = 0.
- IDLE with REQ=0000 stays in IDLE. SEL holds its last value and GNT=0000.
- OWN:
  - VALID = REQ[owner], combinational from the registered owner and the live REQ input.
  - beat_cnt increments on every VALID cycle.
- Release conditions, evaluated at each edge in OWN; any one of them moves state to RELEASE:
  - (a) VALID and LAST.
  - (b) VALID and beat_cnt == MAX_BURST−1 (forced release).
  - (c) REQ[owner]=0, an abort; no beat is counted.
- If (a) and (b) are true on the same beat, exactly one release occurs.
- RELEASE:
  - GNT=0000, VALID=0, SEL held.
  - If REQ≠0000, grant the winner on the next edge (state OWN).
  - Otherwise go to IDLE.
- Requests from non-owners during OWN are ignored until RELEASE.
- A source that is still requesting after its own release may win again only when no other source is requesting, because it now has lowest priority.
- LAST while VALID=0 has no effect.
- Asynchronous reset mid-burst: all registers take their reset values immediately, without waiting for a clock. The burst is dropped and is not resumed.

## Timing
- REQ rises in IDLE → GNT, SEL and VALID are active after 1 edge.
- Beat n is transferred in the cycle where VALID=1. The consumer samples the mux output at the next rising edge.
- Release edge → exactly 1 cycle with GNT=0000 and VALID=0 (RELEASE) → next owner's grant on the following edge.
- Back-to-back owners therefore give: beats of A, 1 dead cycle, beats of B.
- Forced release: at most MAX_BURST VALID cycles per grant. MAX_BURST=1 gives one beat, then RELEASE.
- Abort: a REQ[owner] drop is seen in the same cycle (VALID=0), and the state is RELEASE after the next edge.
- GNT is never multi-hot. SEL changes only on a grant edge.

## Test plan
- Reset:
  - Stimulus: RST_N=0 asserted between edges, with REQ=1111.
  - Response: GNT=0000, SEL=00, VALID=0 and BUSY=0 immediately, and they stay there while RST_N=0.
- Single source:
  - Stimulus: REQ=0100 held, LAST high on the 3rd VALID cycle.
  - Response: GNT=0100 and SEL=10 one edge after REQ; VALID for 3 cycles; 1 cycle with GNT=0000; then re-grant GNT=0100.
- Round-robin:
  - Stimulus: REQ=1111 held, LAST=1 constantly.
  - Response: SEL sequence 00,01,10,11,00; each grant is 1 beat, separated by 1 dead cycle.
- Forced release:
  - Stimulus: MAX_BURST=8, REQ=0011, LAST=0.
  - Response: X1 gets exactly 8 VALID cycles, then RELEASE, then GNT=0010 and SEL=01.
- Abort:
  - Stimulus: REQ=1000 granted, REQ[3] drops after 2 beats while REQ=0001 is asserted.
  - Response: VALID falls in the same cycle; RELEASE on the next edge; then GNT=0001 and SEL=00.
- Reset mid-burst:
  - Stimulus: owner X3 (SEL=10) at beat 4; pulse RST_N low; then REQ=1001.
  - Response: outputs clear asynchronously; the first grant after reset goes to X1 (GNT=0001), and X4 is granted next.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: four-source round-robin arbiter for the 8-bit source-select mux.
// Grants one source at a time, counts beats, forces release after MAX_BURST
// beats and inserts one dead cycle (RELEASE) between consecutive owners.
module bus_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       last,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Beat count value on which the current beat is the final permitted one.
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state_reg, state_next;
  logic [1:0] owner_reg, owner_next;
  logic [1:0] last_owner_reg, last_owner_next;
  logic [7:0] beat_cnt_reg, beat_cnt_next;
  logic [3:0] gnt_reg, gnt_next;

  logic [3:0] req_rot;
  logic [1:0] rot_pick;
  logic [1:0] winner;
  logic       any_req;
  logic       owner_req;
  logic       at_limit;

  // Rotate the request vector so bit 0 is the source right after last_owner,
  // i.e. the highest-priority candidate.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = req[2'(last_owner_reg + 2'(gi + 1))];
    end
  endgenerate

  assign any_req   = |req;
  assign owner_req = req[owner_reg];
  assign at_limit  = (beat_cnt_reg == LAST_BEAT);

  // Fixed-priority pick on the rotated vector, then map back to a source index.
  always_comb begin
    rot_pick = 2'd3;
    if (req_rot[0])      rot_pick = 2'd0;
    else if (req_rot[1]) rot_pick = 2'd1;
    else if (req_rot[2]) rot_pick = 2'd2;
    winner = 2'(last_owner_reg + rot_pick + 2'd1);
  end

  // Next-state and next-register logic for the IDLE/OWN/RELEASE controller.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    gnt_next        = gnt_reg;
    case (state_reg)
      IDLE, RELEASE: begin
        if (any_req) begin
          state_next      = OWN;
          owner_next      = winner;
          last_owner_next = winner;
          beat_cnt_next   = 8'd0;
          gnt_next        = 4'(4'b0001 << winner);
        end else begin
          state_next = IDLE;
          gnt_next   = 4'b0000;
        end
      end
      OWN: begin
        if (!owner_req) begin
          // Abort: owner dropped its request, nothing is counted.
          state_next = RELEASE;
          gnt_next   = 4'b0000;
        end else begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
          if (last || at_limit) begin
            state_next = RELEASE;
            gnt_next   = 4'b0000;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= 2'b00;
      last_owner_reg <= 2'b11;
      beat_cnt_reg   <= 8'd0;
      gnt_reg        <= 4'b0000;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      gnt_reg        <= gnt_next;
    end
  end

  assign sel   = owner_reg;
  assign gnt   = gnt_reg;
  assign valid = (state_reg == OWN) && owner_req;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scenario tasks plus a randomized run, all checked against a
// behavioural model of ownership, dead slots and rotating priority.
module tb_bus_arbiter;

  localparam int MAX_BURST = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       last = 1'b0;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  // Model: which source owns the bus (-1 = none), whether we sit in the dead
  // slot, the select value, the most recent winner and beats taken so far.
  int m_owner;
  bit m_dead;
  int m_sel;
  int m_last;
  int m_beats;

  bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .last  (last),
    .sel   (sel),
    .gnt   (gnt),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_dead  = 0;
    m_sel   = 0;
    m_last  = 3;
    m_beats = 0;
  endtask

  // Expected {gnt, sel, valid, busy} for the current model state and live req.
  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    logic       v;
    g = 4'b0000;
    v = 1'b0;
    if (m_owner >= 0) begin
      g = 4'(1 << m_owner);
      v = req[m_owner];
    end
    return {g, 2'(m_sel), v, (m_owner >= 0) || m_dead};
  endfunction

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_edge();
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        m_dead  = 1;
      end else begin
        m_beats++;
        if (last || m_beats == MAX_BURST) begin
          m_owner = -1;
          m_dead  = 1;
        end
      end
    end else begin
      m_dead = 0;
      for (int k = 1; k <= 4; k++) begin
        if (req[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          break;
        end
      end
      if (m_owner >= 0) begin
        m_sel   = m_owner;
        m_last  = m_owner;
        m_beats = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req   = 4'b0000;
    last  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req  = 4'b1111;
    last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if ({gnt, sel, valid, busy} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_pre cyc%0d: got %b want %b", i, {gnt, sel, valid, busy}, exp_vec());
      end
      tick();
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({gnt, sel, valid, busy} !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL reset_async: got gnt=%b sel=%b valid=%b busy=%b want all zero", gnt, sel, valid, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({gnt, sel, valid, busy} !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL reset_hold: got gnt=%b sel=%b valid=%b busy=%b want all zero", gnt, sel, valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;
  endtask

  task automatic test_single_source();
    logic [3:0] g_exp [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    logic       v_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    req = 4'b0100;
    tick();
    for (int i = 0; i < 5; i++) begin
      last = (i == 2);
      #1;
      vectors++;
      if ({gnt, sel, valid, busy} !== exp_vec() || gnt !== g_exp[i] || valid !== v_exp[i]
          || (gnt != 4'b0000 && sel !== 2'b10)) begin
        errors++;
        $display("FAIL single cyc%0d: got gnt=%b sel=%b valid=%b want gnt=%b sel=10 valid=%b",
                 i, gnt, sel, valid, g_exp[i], v_exp[i]);
      end
      tick();
    end
    req  = 4'b0000;
    last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({gnt, sel, valid, busy} !== exp_vec()) begin
        errors++;
        $display("FAIL single_drain cyc%0d: got %b want %b", i, {gnt, sel, valid, busy}, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req  = 4'b1111;
    last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      vectors++;
      if ({gnt, sel, valid, busy} !== exp_vec()) begin
        errors++;
        $display("FAIL rr_model cyc%0d: got %b want %b", i, {gnt, sel, valid, busy}, exp_vec());
      end
      if (i % 2 == 1) begin
        vectors++;
        if (sel !== 2'((i / 2) % 4) || gnt !== 4'(1 << ((i / 2) % 4)) || valid !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant cyc%0d: got sel=%b gnt=%b valid=%b want sel=%0d", i, sel, gnt, valid, (i / 2) % 4);
        end
      end else if (i > 0) begin
        vectors++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rr_dead cyc%0d: got gnt=%b valid=%b busy=%b want 0000/0/1", i, gnt, valid, busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_forced_release();
    apply_reset();
    req  = 4'b0011;
    last = 1'b0;
    for (int i = 0; i < 11; i++) begin
      #1;
      vectors++;
      if ({gnt, sel, valid, busy} !== exp_vec()) begin
        errors++;
        $display("FAIL forced_model cyc%0d: got %b want %b", i, {gnt, sel, valid, busy}, exp_vec());
      end
      if (i >= 1 && i <= 8) begin
        vectors++;
        if (gnt !== 4'b0001 || sel !== 2'b00 || valid !== 1'b1) begin
          errors++;
          $display("FAIL forced_beat cyc%0d: got gnt=%b sel=%b valid=%b want 0001/00/1", i, gnt, sel, valid);
        end
      end else if (i == 9) begin
        vectors++;
        if (gnt !== 4'b0000 || valid !== 1'b0) begin
          errors++;
          $display("FAIL forced_release: got gnt=%b valid=%b want 0000/0", gnt, valid);
        end
      end else if (i == 10) begin
        vectors++;
        if (gnt !== 4'b0010 || sel !== 2'b01) begin
          errors++;
          $display("FAIL forced_next: got gnt=%b sel=%b want 0010/01", gnt, sel);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    apply_reset();
    req  = 4'b1000;
    last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) req = 4'b0001;
      #1;
      vectors++;
      if ({gnt, sel, valid, busy} !== exp_vec()) begin
        errors++;
        $display("FAIL abort_model cyc%0d: got %b want %b", i, {gnt, sel, valid, busy}, exp_vec());
      end
      if (i == 3) begin
        vectors++;
        if (valid !== 1'b0 || gnt !== 4'b1000 || sel !== 2'b11) begin
          errors++;
          $display("FAIL abort_drop: got valid=%b gnt=%b sel=%b want 0/1000/11", valid, gnt, sel);
        end
      end else if (i == 4) begin
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
          errors++;
          $display("FAIL abort_release: got gnt=%b busy=%b want 0000/1", gnt, busy);
        end
      end else if (i == 5) begin
        vectors++;
        if (gnt !== 4'b0001 || sel !== 2'b00 || valid !== 1'b1) begin
          errors++;
          $display("FAIL abort_next: got gnt=%b sel=%b valid=%b want 0001/00/1", gnt, sel, valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req  = 4'b0100;
    last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({gnt, sel, valid, busy} !== exp_vec()) begin
        errors++;
        $display("FAIL midrst_model cyc%0d: got %b want %b", i, {gnt, sel, valid, busy}, exp_vec());
      end
      if (i < 4) tick();
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({gnt, sel, valid, busy} !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL midrst_async: got gnt=%b sel=%b valid=%b busy=%b want all zero", gnt, sel, valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1001;
    last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if ({gnt, sel, valid, busy} !== exp_vec()) begin
        errors++;
        $display("FAIL midrst_after cyc%0d: got %b want %b", i, {gnt, sel, valid, busy}, exp_vec());
      end
      if (i == 1) begin
        vectors++;
        if (gnt !== 4'b0001 || sel !== 2'b00) begin
          errors++;
          $display("FAIL midrst_first: got gnt=%b sel=%b want 0001/00", gnt, sel);
        end
      end else if (i == 3) begin
        vectors++;
        if (gnt !== 4'b1000 || sel !== 2'b11) begin
          errors++;
          $display("FAIL midrst_second: got gnt=%b sel=%b want 1000/11", gnt, sel);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      last = ($urandom_range(0, 3) == 0);
      #1;
      vectors++;
      if ({gnt, sel, valid, busy} !== exp_vec() || !$onehot0(gnt)) begin
        errors++;
        $display("FAIL random cyc%0d req=%b last=%b: got %b want %b", i, req, last,
                 {gnt, sel, valid, busy}, exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_source();
    test_round_robin();
    test_forced_release();
    test_abort();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
